udp_rx_pkt_queue: RTL

UDP_RX_PKT_QUEUE -- requirements
Module: udp_rx_pkt_queue

---
 rtl/udp_rx_pkt_queue.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/udp_rx_pkt_queue.sv
// Receive-side UDP packet queue: a ring of fixed-size slots filled word by word, read as a random-access head slot.
// Full/filter/zero-length packets are dropped whole, with a one-cycle strobe and a saturating drop counter.
module udp_rx_pkt_queue #(
  parameter  int DATA_W     = 32,
  parameter  int NUM_SLOTS  = 4,
  parameter  int SLOT_BYTES = 256,
  parameter  int SWAP_BYTES = 1,
  localparam int SLOT_WORDS = SLOT_BYTES / (DATA_W / 8),
  localparam int AW         = $clog2(SLOT_WORDS),
  localparam int CW         = $clog2(NUM_SLOTS) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_wr_en,
  input  logic [DATA_W-1:0] in_wr_data,
  input  logic              in_pkt_done,
  input  logic [15:0]       in_byte_num,
  input  logic [15:0]       in_src_port,
  input  logic [15:0]       in_dest_port,
  input  logic              filter_en,
  input  logic [15:0]       filter_port,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              pop,
  output logic              pkt_avail,
  output logic [15:0]       pkt_length,
  output logic [15:0]       pkt_src_port,
  output logic [15:0]       pkt_dest_port,
  output logic              pkt_trunc,
  output logic [CW-1:0]     pkt_count,
  output logic [15:0]       drop_count,
  output logic              drop_pulse
);

  localparam int BYTES = DATA_W / 8;
  localparam int SW    = $clog2(NUM_SLOTS);
  localparam int DEPTH = NUM_SLOTS << AW;
  localparam logic [15:0] SLOT_BYTES_L = 16'(SLOT_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DISCARD} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   wr_slot_q, wr_slot_d, rd_slot_q, rd_slot_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   widx_q, widx_d, wr_idx;
  logic            full_q, full_d, lost_q, lost_d, lost_now;
  logic [15:0]     drop_count_q;
  logic            drop_pulse_q;
  logic [DATA_W-1:0] rd_data_q, wdata;
  logic            mem_we, end_pkt, commit, drop, reject, has_space, word_vld, pop_vld;
  logic            trunc_new;
  logic [15:0]     len_new;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [15:0]       len_q   [NUM_SLOTS];
  logic [15:0]       src_q   [NUM_SLOTS];
  logic [15:0]       dst_q   [NUM_SLOTS];
  logic              trunc_q [NUM_SLOTS];

  assign word_vld  = in_wr_en | in_pkt_done;
  assign has_space = (count_q != CW'(NUM_SLOTS));
  assign reject    = (in_byte_num == 16'd0) | (filter_en & (in_dest_port != filter_port));
  assign pop_vld   = pop & (count_q != '0);

  always_comb begin
    wdata = in_wr_data;
    if (SWAP_BYTES == 1) begin
      for (int i = 0; i < BYTES; i++) begin
        wdata[i*8 +: 8] = in_wr_data[(BYTES-1-i)*8 +: 8];
      end
    end
  end

  // Space is checked only at a packet's first word; once in DISCARD the packet stays dropped.
  always_comb begin
    state_d  = state_q;
    widx_d   = widx_q;
    full_d   = full_q;
    lost_d   = lost_q;
    lost_now = lost_q;
    wr_idx   = widx_q;
    mem_we   = 1'b0;
    end_pkt  = 1'b0;
    drop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (word_vld) begin
          if (has_space) begin
            mem_we   = 1'b1;
            wr_idx   = '0;
            lost_now = 1'b0;
            if (in_pkt_done) begin
              end_pkt = 1'b1;
            end else begin
              state_d = S_FILL;
              widx_d  = AW'(1);
              full_d  = 1'b0;
              lost_d  = 1'b0;
            end
          end else if (in_pkt_done) begin
            drop = 1'b1;
          end else begin
            state_d = S_DISCARD;
          end
        end
      end
      S_FILL: begin
        if (word_vld) begin
          if (full_q) lost_now = 1'b1;
          else        mem_we   = 1'b1;
          if (in_pkt_done) begin
            end_pkt = 1'b1;
            state_d = S_IDLE;
          end else begin
            lost_d = lost_now;
            if (!full_q) begin
              if (widx_q == AW'(SLOT_WORDS - 1)) full_d = 1'b1;
              else                               widx_d = widx_q + AW'(1);
            end
          end
        end
      end
      S_DISCARD: begin
        if (in_pkt_done) begin
          drop    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (end_pkt && reject) drop = 1'b1;
  end

  assign commit    = end_pkt & ~reject;
  assign trunc_new = lost_now | (in_byte_num > SLOT_BYTES_L);
  assign len_new   = (in_byte_num > SLOT_BYTES_L) ? SLOT_BYTES_L : in_byte_num;

  always_comb begin
    wr_slot_d = wr_slot_q + (commit  ? SW'(1) : SW'(0));
    rd_slot_d = rd_slot_q + (pop_vld ? SW'(1) : SW'(0));
    count_d   = count_q;
    case ({commit, pop_vld})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_slot_q    <= '0;
      rd_slot_q    <= '0;
      count_q      <= '0;
      widx_q       <= '0;
      full_q       <= 1'b0;
      lost_q       <= 1'b0;
      drop_count_q <= '0;
      drop_pulse_q <= 1'b0;
      rd_data_q    <= '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        len_q[s]   <= '0;
        src_q[s]   <= '0;
        dst_q[s]   <= '0;
        trunc_q[s] <= 1'b0;
      end
    end else begin
      state_q      <= state_d;
      wr_slot_q    <= wr_slot_d;
      rd_slot_q    <= rd_slot_d;
      count_q      <= count_d;
      widx_q       <= widx_d;
      full_q       <= full_d;
      lost_q       <= lost_d;
      drop_pulse_q <= drop;
      rd_data_q    <= mem_q[{rd_slot_q, rd_addr}];
      if (drop && (drop_count_q != 16'hFFFF)) drop_count_q <= drop_count_q + 16'd1;
      if (commit) begin
        len_q[wr_slot_q]   <= len_new;
        src_q[wr_slot_q]   <= in_src_port;
        dst_q[wr_slot_q]   <= in_dest_port;
        trunc_q[wr_slot_q] <= trunc_new;
      end
    end
  end

  // Payload RAM carries no reset; stale contents are never visible as a committed packet.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[{wr_slot_q, wr_idx}] <= wdata;
  end

  assign rd_data       = rd_data_q;
  assign pkt_avail     = (count_q != '0);
  assign pkt_length    = len_q[rd_slot_q];
  assign pkt_src_port  = src_q[rd_slot_q];
  assign pkt_dest_port = dst_q[rd_slot_q];
  assign pkt_trunc     = trunc_q[rd_slot_q];
  assign pkt_count     = count_q;
  assign drop_count    = drop_count_q;
  assign drop_pulse    = drop_pulse_q;

endmodule
